// File: rtl/skew_buf.sv
// Per-lane delay line that skews (or deskews) a DIM-lane data beat across lanes.
// Lane latency depends on the active mode, which is only allowed to change while the buffer is idle.
module skew_buf #(
  parameter int BITS_AB    = 8,
  parameter int DIM        = 8,
  parameter int BASE_DEPTH = 8,
  parameter int STEP       = 1
) (
  input  logic                              clk,
  input  logic                              rst,
  input  logic                              en,
  input  logic                              flush,
  input  logic                              mode,
  input  logic signed [DIM-1:0][BITS_AB-1:0] din,
  input  logic                              vin,
  output logic signed [DIM-1:0][BITS_AB-1:0] dout,
  output logic [DIM-1:0]                    vout,
  output logic                              busy,
  output logic                              done
);

  localparam int   DEPTH     = BASE_DEPTH + STEP * (DIM - 1);
  localparam logic MODE_SKEW = 1'b0;

  // Lane latency in enabled cycles; m=1 reverses the lane order (DESKEW).
  function automatic int lane_lat(input logic m, input int lane);
    return m ? (BASE_DEPTH + STEP * (DIM - 1 - lane)) : (BASE_DEPTH + STEP * lane);
  endfunction

  logic [DIM-1:0][DEPTH-1:0]              r_vld;
  logic [DIM-1:0][DEPTH-1:0][BITS_AB-1:0] r_dat;
  logic [DIM-1:0]                         r_vout;
  logic [DIM-1:0][BITS_AB-1:0]            r_dout;
  logic                                   r_mode;
  logic                                   r_busy_q;
  logic                                   r_flushed;

  logic [DIM-1:0]                         w_tap_v;
  logic [DIM-1:0][BITS_AB-1:0]            w_tap_d;
  logic [DIM-1:0]                         w_lane_busy;
  logic                                   w_busy;

  // Tap selection and occupancy only look at stages 0..L_i-1 of each lane.
  always_comb begin
    for (int i = 0; i < DIM; i++) begin
      w_tap_v[i]     = 1'b0;
      w_tap_d[i]     = '0;
      w_lane_busy[i] = 1'b0;
      for (int k = 0; k < DEPTH; k++) begin
        if (k == lane_lat(r_mode, i) - 1) begin
          w_tap_v[i] = r_vld[i][k];
          w_tap_d[i] = r_dat[i][k];
        end
        if (k < lane_lat(r_mode, i)) begin
          w_lane_busy[i] = w_lane_busy[i] | r_vld[i][k];
        end
      end
    end
  end

  assign w_busy = |w_lane_busy;

  always_ff @(posedge clk) begin
    if (rst || flush) begin
      r_vld <= '0;
      r_dat <= '0;
    end else if (en) begin
      for (int i = 0; i < DIM; i++) begin
        r_vld[i] <= (r_vld[i] << 1) | DEPTH'(vin);
        r_dat[i] <= (r_dat[i] << BITS_AB) | (DEPTH*BITS_AB)'($unsigned(din[i]));
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst || flush) begin
      r_vout <= '0;
      r_dout <= '0;
    end else if (en) begin
      for (int i = 0; i < DIM; i++) begin
        r_vout[i] <= w_tap_v[i];
        r_dout[i] <= w_tap_v[i] ? w_tap_d[i] : '0;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_mode <= MODE_SKEW;
    end else if (!w_busy && !en) begin
      r_mode <= mode;
    end
  end

  // Remember whether the previous edge was a flush so a flushed drain gives no done.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_busy_q  <= 1'b0;
      r_flushed <= 1'b0;
    end else begin
      r_busy_q  <= w_busy;
      r_flushed <= flush;
    end
  end

  assign dout = r_dout;
  assign vout = r_vout;
  assign busy = w_busy;
  assign done = r_busy_q & ~w_busy & ~r_flushed;

endmodule

// File: tb/tb_skew_buf.sv
// Directed bench for skew_buf with DIM=4, BASE_DEPTH=1, STEP=1, BITS_AB=8.
// A vector table covers SKEW/DESKEW bursts; hand sequences cover stall, flush, mode change and reset.
module tb_skew_buf;

  logic                     clk = 1'b0;
  logic                     rst;
  logic                     en;
  logic                     flush;
  logic                     mode;
  logic signed [3:0][7:0]   din;
  logic                     vin;
  logic signed [3:0][7:0]   dout;
  logic [3:0]               vout;
  logic                     busy;
  logic                     done;

  int n_tests = 0;
  int n_fail  = 0;

  localparam logic [31:0] D_IN = {8'd13, 8'd12, 8'd11, 8'd10};

  typedef struct {
    string       name;
    logic        en;
    logic        flush;
    logic        vin;
    logic        mode;
    logic [31:0] din;
    logic [3:0]  e_vout;
    logic [31:0] e_dout;
    logic        e_busy;
    logic        e_done;
  } vec_t;

  vec_t vecs[$];

  skew_buf #(.BITS_AB(8), .DIM(4), .BASE_DEPTH(1), .STEP(1)) dut (
    .clk   (clk),
    .rst   (rst),
    .en    (en),
    .flush (flush),
    .mode  (mode),
    .din   (din),
    .vin   (vin),
    .dout  (dout),
    .vout  (vout),
    .busy  (busy),
    .done  (done)
  );

  always #5 clk = ~clk;

  function automatic logic [31:0] lane(input int i, input int v);
    return 32'(v & 8'hFF) << (8 * i);
  endfunction

  function automatic vec_t mk(input string nm, input logic e, input logic f, input logic v,
                              input logic m, input logic [31:0] d, input logic [3:0] ev,
                              input logic [31:0] ed, input logic eb, input logic edn);
    vec_t r;
    r.name = nm; r.en = e; r.flush = f; r.vin = v; r.mode = m; r.din = d;
    r.e_vout = ev; r.e_dout = ed; r.e_busy = eb; r.e_done = edn;
    return r;
  endfunction

  // Drive one edge's worth of inputs, then sample 1 time unit after the edge.
  task automatic apply(input logic r, input logic e, input logic f, input logic v,
                       input logic m, input logic [31:0] d);
    rst = r; en = e; flush = f; vin = v; mode = m; din = d;
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string nm, input logic [3:0] ev, input logic [31:0] ed,
                     input logic eb, input logic edn);
    logic [37:0] act;
    logic [37:0] exp;
    act = {vout, dout, busy, done};
    exp = {ev, ed, eb, edn};
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: vout=%b dout=%h busy=%b done=%b, expected vout=%b dout=%h busy=%b done=%b",
               nm, vout, dout, busy, done, ev, ed, eb, edn);
    end
  endtask

  initial begin
    // SKEW burst: lane i appears i+1 edges after the input beat.
    vecs.push_back(mk("sk_idle", 0, 0, 0, 0, 0,    4'b0000, 0,           0, 0));
    vecs.push_back(mk("sk_e0",   1, 0, 1, 0, D_IN, 4'b0000, 0,           1, 0));
    vecs.push_back(mk("sk_e1",   1, 0, 0, 0, 0,    4'b0001, lane(0, 10), 1, 0));
    vecs.push_back(mk("sk_e2",   1, 0, 0, 0, 0,    4'b0010, lane(1, 11), 1, 0));
    vecs.push_back(mk("sk_e3",   1, 0, 0, 0, 0,    4'b0100, lane(2, 12), 1, 0));
    vecs.push_back(mk("sk_e4",   1, 0, 0, 0, 0,    4'b1000, lane(3, 13), 0, 1));
    vecs.push_back(mk("sk_e5",   1, 0, 0, 0, 0,    4'b0000, 0,           0, 0));
    // DESKEW: mode loaded on an idle en=0 edge, lane 3 leads.
    vecs.push_back(mk("dk_load", 0, 0, 0, 1, 0,    4'b0000, 0,           0, 0));
    vecs.push_back(mk("dk_e0",   1, 0, 1, 1, D_IN, 4'b0000, 0,           1, 0));
    vecs.push_back(mk("dk_e1",   1, 0, 0, 1, 0,    4'b1000, lane(3, 13), 1, 0));
    vecs.push_back(mk("dk_e2",   1, 0, 0, 1, 0,    4'b0100, lane(2, 12), 1, 0));
    vecs.push_back(mk("dk_e3",   1, 0, 0, 1, 0,    4'b0010, lane(1, 11), 1, 0));
    vecs.push_back(mk("dk_e4",   1, 0, 0, 1, 0,    4'b0001, lane(0, 10), 0, 1));
    vecs.push_back(mk("dk_e5",   1, 0, 0, 1, 0,    4'b0000, 0,           0, 0));

    // Reset with every other control active: reset must win.
    apply(1, 1, 1, 1, 1, D_IN);
    apply(1, 1, 0, 1, 1, D_IN);
    chk("reset", 4'b0000, 0, 0, 0);

    foreach (vecs[i]) begin
      apply(0, vecs[i].en, vecs[i].flush, vecs[i].vin, vecs[i].mode, vecs[i].din);
      chk(vecs[i].name, vecs[i].e_vout, vecs[i].e_dout, vecs[i].e_busy, vecs[i].e_done);
    end

    // Stall: 3 en=0 edges mid-drain hold outputs and delay later lanes by 3.
    apply(0, 0, 0, 0, 0, 0);    chk("st_load", 4'b0000, 0, 0, 0);
    apply(0, 1, 0, 1, 0, D_IN); chk("st_e0", 4'b0000, 0, 1, 0);
    apply(0, 1, 0, 0, 0, 0);    chk("st_e1", 4'b0001, lane(0, 10), 1, 0);
    for (int s = 0; s < 3; s++) begin
      apply(0, 0, 0, 0, 0, 0);  chk("st_hold", 4'b0001, lane(0, 10), 1, 0);
    end
    apply(0, 1, 0, 0, 0, 0);    chk("st_e2", 4'b0010, lane(1, 11), 1, 0);
    apply(0, 1, 0, 0, 0, 0);    chk("st_e3", 4'b0100, lane(2, 12), 1, 0);
    apply(0, 1, 0, 0, 0, 0);    chk("st_e4", 4'b1000, lane(3, 13), 0, 1);
    apply(0, 1, 0, 0, 0, 0);    chk("st_e5", 4'b0000, 0, 0, 0);

    // Flush at edge 2: everything clears, no done afterwards.
    apply(0, 1, 0, 1, 0, D_IN); chk("fl_e0", 4'b0000, 0, 1, 0);
    apply(0, 1, 0, 0, 0, 0);    chk("fl_e1", 4'b0001, lane(0, 10), 1, 0);
    apply(0, 1, 1, 0, 0, 0);    chk("fl_e2", 4'b0000, 0, 0, 0);
    apply(0, 1, 0, 0, 0, 0);    chk("fl_nodone", 4'b0000, 0, 0, 0);
    // A beat presented together with flush is dropped.
    apply(0, 1, 1, 1, 0, D_IN); chk("fl_vin", 4'b0000, 0, 0, 0);
    for (int s = 0; s < 4; s++) begin
      apply(0, 1, 0, 0, 0, 0);  chk("fl_vin_drop", 4'b0000, 0, 0, 0);
    end

    // Mode requested while busy: SKEW timing kept until drained.
    apply(0, 1, 0, 1, 0, D_IN); chk("md_e0", 4'b0000, 0, 1, 0);
    apply(0, 1, 0, 0, 1, 0);    chk("md_e1", 4'b0001, lane(0, 10), 1, 0);
    apply(0, 0, 0, 0, 1, 0);    chk("md_stall", 4'b0001, lane(0, 10), 1, 0);
    apply(0, 1, 0, 0, 1, 0);    chk("md_e2", 4'b0010, lane(1, 11), 1, 0);
    apply(0, 1, 0, 0, 1, 0);    chk("md_e3", 4'b0100, lane(2, 12), 1, 0);
    apply(0, 1, 0, 0, 1, 0);    chk("md_e4", 4'b1000, lane(3, 13), 0, 1);
    apply(0, 1, 0, 0, 1, 0);    chk("md_e5", 4'b0000, 0, 0, 0);
    apply(0, 0, 0, 0, 1, 0);    chk("md_load", 4'b0000, 0, 0, 0);
    apply(0, 1, 0, 1, 1, D_IN); chk("md_n0", 4'b0000, 0, 1, 0);
    apply(0, 1, 0, 0, 1, 0);    chk("md_n1", 4'b1000, lane(3, 13), 1, 0);
    apply(0, 1, 0, 0, 1, 0);    chk("md_n2", 4'b0100, lane(2, 12), 1, 0);

    // Reset at edge 2 of a DESKEW burst: outputs clear, no done, mode back to SKEW.
    apply(0, 1, 0, 0, 0, 0);    chk("md_n3", 4'b0010, lane(1, 11), 1, 0);
    apply(0, 1, 0, 0, 0, 0);    chk("md_n4", 4'b0001, lane(0, 10), 0, 1);
    apply(0, 1, 0, 1, 0, D_IN); chk("rs_e0", 4'b0000, 0, 1, 0);
    apply(0, 1, 0, 0, 0, 0);    chk("rs_e1", 4'b1000, lane(3, 13), 1, 0);
    apply(1, 1, 0, 0, 0, 0);    chk("rs_e2", 4'b0000, 0, 0, 0);
    apply(0, 1, 0, 0, 0, 0);    chk("rs_nodone", 4'b0000, 0, 0, 0);
    apply(0, 1, 0, 1, 0, D_IN); chk("rs_n0", 4'b0000, 0, 1, 0);
    apply(0, 1, 0, 0, 0, 0);    chk("rs_skew", 4'b0001, lane(0, 10), 1, 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
